if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction-fetch stage of the 32-bit RISC-V pipeline: owns the program counter, issues one-outstanding-request reads to instruction memory, and presents `{pc, instruction, valid}` to the IF/ID pipeline register. It absorbs IF/ID stalls with a one-entry hold buffer and handles branch/jump redirects from EX, including redirects that arrive while a memory request is in flight. When no valid instruction is available it drives a NOP bubble, so the IF/ID register needs no valid bit.

## Interface
- `DATAWIDTH`, 32, PC/instruction width.
- `RESET_PC`, 32'h0000_0000, first fetch address.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req` output 1: fetch request, held until `imem_ack`.
- `imem_addr` output 32: fetch address, stable while `imem_req` is high.
- `imem_ack` input 1: `imem_rdata` valid this cycle; may be high in the same cycle as `imem_req` (zero-wait).
- `imem_rdata` input 32: fetched instruction.
- `stall_f` input 1: IF/ID is not capturing this cycle (its `en` = ~`stall_f`).
- `redirect` input 1: taken branch/jump from EX.
- `redirect_pc` input 32: target; bits [1:0] forced to 0.
- `pcf_out` output 32: PC of the presented instruction (to IF/ID `pcd_in`).
- `instf_out` output 32: instruction, or NOP 32'h0000_0013 when not valid (to IF/ID `instd_in`).
- `validf_out` output 1: `instf_out` is a real instruction.

## Operation
- Registers: `pc`, `hold_buf`, `tgt` (pending redirect), `state`.
- States:
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`.
  - HOLD: instruction buffered; `imem_req`=0.
  - KILL: stale request outstanding; `imem_req`=1 and `imem_addr`=`pc`.
- Priority: `rst` > `redirect` > `stall_f`.
- FETCH transitions:
  - `ack` & ~`redirect` & ~`stall_f`: present `imem_rdata` as valid; `pc`<=`pc`+4; stay in FETCH.
  - `ack` & ~`redirect` & `stall_f`: present it as valid; `hold_buf`<=`imem_rdata`; go to HOLD (`pc` unchanged).
  - `ack` & `redirect`: discard; `pc`<=`redirect_pc`; stay in FETCH.
  - ~`ack` & `redirect`: `tgt`<=`redirect_pc`; go to KILL. The address is never changed mid-request.
  - ~`ack` & ~`redirect`: wait.
- HOLD transitions:
  - ~`redirect` & ~`stall_f`: present `hold_buf` as valid; `pc`<=`pc`+4; go to FETCH.
  - ~`redirect` & `stall_f`: present `hold_buf` as valid; stay in HOLD.
  - `redirect`: discard buffer; `pc`<=`redirect_pc`; go to FETCH.
- KILL transitions:
  - Outputs are never valid.
  - `redirect`: `tgt`<=`redirect_pc` (latest redirect wins).
  - `ack`: discard data; `pc`<=(`redirect` ? `redirect_pc` : `tgt`); go to FETCH.
- `validf_out` = (FETCH & `ack` & ~`redirect`) | (HOLD & ~`redirect`). When `validf_out` is 0: `instf_out`=NOP.
- `pcf_out` = `pc` in every state.
- Arithmetic: `pc`+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0).

## Timing
- Reset (`rst` high at an edge):
  - State after reset: `state`=FETCH, `pc`=`RESET_PC`, `hold_buf`=0, `tgt`=0.
  - Outputs while `rst` is high: `imem_req`=0, `validf_out`=0, `instf_out`=NOP, `pcf_out`=`pc`.
- First request: the cycle after `rst` drops.
- Reset mid-request: abandons the request without waiting for `ack`. The memory must tolerate the dropped `req`.
- Latency: `imem_ack` to `validf_out` is 0 cycles (combinational). The IF/ID register captures at the same edge if ~`stall_f`.
- Throughput: with zero-wait memory and no stalls, 1 instruction/cycle.
- Redirect cost:
  - From FETCH-with-`ack` or HOLD: the target request is issued on the next cycle.
  - From KILL: the target request is issued on the cycle after the stale `ack`.
- Stall then release: the held instruction is presented every stalled cycle. A new request is issued the cycle after the release edge.
- A redirect in the same cycle as `stall_f` still redirects; the hazard unit flushes IF/ID separately.

## Structure
- Shared package `rv32_pipe_pkg`:
  - `NOP_INSTR` = 32'h0000_0013.
  - `RESET_PC` default.
  - Fetch state enum {FETCH, HOLD, KILL}.
- One sub-module, `if_fetch_ctrl`: state register and next-state/control decode.
- Datapath in the top level: `pc`, `hold_buf`, `tgt`, adder, output muxes.

## Test plan
- Reset with `RESET_PC`=0x100, zero-wait memory, no stall -> requests to 0x100, 0x104, 0x108 on consecutive cycles; `validf_out`=1 each cycle with matching `pcf_out`.
- `ack` delayed 3 cycles for 0x100 -> `imem_addr` held at 0x100 and `validf_out`=0 for 3 cycles; instruction presented in the `ack` cycle.
- `stall_f`=1 for 2 cycles when 0x104 returns -> `validf_out`=1 with the same 0x104 instruction for 3 cycles, `imem_req`=0; 0x108 requested after release.
- `redirect` to 0x200 while the 0x108 request is outstanding, `ack` 2 cycles later -> stale data never valid; next request is 0x200.
- Two redirects during KILL (0x200, then 0x300) -> fetch resumes at 0x300.
- `RESET_PC`=0xFFFF_FFFC -> second fetch address is 0x0000_0000. `rst` asserted mid-wait -> `imem_req`=0 and `validf_out`=0 in the reset cycle.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32 pipeline: the NOP bubble, the reset PC default
// and the encodings used by the fetch stage.
package rv32_pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_e;

  // Next-PC source chosen by the fetch controller.
  typedef enum logic [1:0] {
    PC_KEEP  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_TGT   = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: FETCH/HOLD/KILL state register plus the decode of
// request, valid and datapath load/select strobes.
module if_fetch_ctrl
  import rv32_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         imem_ack_i,
  input  logic         stall_f_i,
  input  logic         redirect_i,
  output fetch_state_e state_o,
  output logic         imem_req_o,
  output logic         valid_o,
  output logic         hold_load_o,
  output logic         tgt_load_o,
  output pc_sel_e      pc_sel_o
);

  fetch_state_e state_q, state_d;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    imem_req_o  = 1'b0;
    valid_o     = 1'b0;
    hold_load_o = 1'b0;
    tgt_load_o  = 1'b0;
    pc_sel_o    = PC_KEEP;

    case (state_q)
      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          if (redirect_i) begin
            pc_sel_o = PC_REDIR;
          end else begin
            valid_o = 1'b1;
            if (stall_f_i) begin
              hold_load_o = 1'b1;
              state_d     = HOLD;
            end else begin
              pc_sel_o = PC_INC;
            end
          end
        end else if (redirect_i) begin
          // The address must not move mid-request, so park the target until the ack.
          tgt_load_o = 1'b1;
          state_d    = KILL;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          pc_sel_o = PC_REDIR;
          state_d  = FETCH;
        end else begin
          valid_o = 1'b1;
          if (!stall_f_i) begin
            pc_sel_o = PC_INC;
            state_d  = FETCH;
          end
        end
      end

      KILL: begin
        imem_req_o = 1'b1;
        tgt_load_o = redirect_i;
        if (imem_ack_i) begin
          pc_sel_o = redirect_i ? PC_REDIR : PC_TGT;
          state_d  = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    if (rst) begin
      imem_req_o = 1'b0;
      valid_o    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: PC, one-entry hold buffer and pending-redirect
// target, feeding {pc, instruction, valid} to the IF/ID register.
module if_fetch_stage
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned          DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [DATAWIDTH-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [DATAWIDTH-1:0] imem_rdata,
  input  logic                 stall_f,
  input  logic                 redirect,
  input  logic [DATAWIDTH-1:0] redirect_pc,
  output logic [DATAWIDTH-1:0] pcf_out,
  output logic [DATAWIDTH-1:0] instf_out,
  output logic                 validf_out
);

  logic [DATAWIDTH-1:0] pc_q, hold_q, tgt_q;
  logic [DATAWIDTH-1:0] redirect_al;
  fetch_state_e         state;
  logic                 hold_load, tgt_load;
  pc_sel_e              pc_sel;

  assign redirect_al = {redirect_pc[DATAWIDTH-1:2], 2'b00};

  if_fetch_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .imem_ack_i (imem_ack),
    .stall_f_i  (stall_f),
    .redirect_i (redirect),
    .state_o    (state),
    .imem_req_o (imem_req),
    .valid_o    (validf_out),
    .hold_load_o(hold_load),
    .tgt_load_o (tgt_load),
    .pc_sel_o   (pc_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      hold_q <= '0;
      tgt_q  <= '0;
    end else begin
      case (pc_sel)
        PC_INC:   pc_q <= pc_q + DATAWIDTH'(4);
        PC_REDIR: pc_q <= redirect_al;
        PC_TGT:   pc_q <= tgt_q;
        default:  pc_q <= pc_q;
      endcase
      if (hold_load) hold_q <= imem_rdata;
      if (tgt_load)  tgt_q  <= redirect_al;
    end
  end

  assign imem_addr = pc_q;
  assign pcf_out   = pc_q;

  // A bubble is a real NOP, so IF/ID never needs its own valid bit.
  always_comb begin
    instf_out = DATAWIDTH'(NOP_INSTR);
    if (validf_out) instf_out = (state == HOLD) ? hold_q : imem_rdata;
  end

endmodule
